// File: rtl/move_position_encoder_pkg.sv
// Shared constants, FSM encoding and one-hot helpers for the keypad move encoder.
package move_position_encoder_pkg;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned POS_W   = 4;
    localparam logic [POS_W-1:0] POS_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        HOLD,
        RELEASE
    } state_e;

    function automatic logic [3:0] popcount(input logic [N_CELLS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < N_CELLS; k++) begin
            n = n + 4'(v[k]);
        end
        return n;
    endfunction

    // OR of every set bit's position: exact for one-hot input, no priority chain.
    function automatic logic [POS_W-1:0] encode_onehot(input logic [N_CELLS-1:0] v);
        logic [POS_W-1:0] pos;
        pos = POS_NONE;
        for (int k = 0; k < N_CELLS; k++) begin
            if (v[k]) pos = pos | POS_W'(k + 1);
        end
        return pos;
    endfunction

endpackage

// File: rtl/move_position_encoder_if.sv
// Keypad-to-controller bundle: raw keys and board state in, position handshake and error pulses out.
interface move_position_encoder_if;
    import move_position_encoder_pkg::*;

    logic [N_CELLS-1:0] key_in;
    logic [N_CELLS-1:0] board_occ;
    logic [POS_W-1:0]   pos_out;
    logic               pos_valid;
    logic               pos_ready;
    logic               err_multi;
    logic               err_occ;

    modport master (
        input  key_in, board_occ, pos_ready,
        output pos_out, pos_valid, err_multi, err_occ
    );

    modport slave (
        output key_in, board_occ, pos_ready,
        input  pos_out, pos_valid, err_multi, err_occ
    );

endinterface

// File: rtl/move_position_encoder_key_debouncer.sv
// Two-flop synchroniser plus hold-time debouncer; key_stable updates only after the synced
// vector has been unchanged for DEBOUNCE_CYCLES cycles.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WIDTH           = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             changed;

    // sync1_q is the next value of the synced vector, so a mismatch marks a change one cycle early.
    assign changed = (sync1_q != sync2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            key_stable <= '0;
        end else begin
            // NOTE: non-blocking assignments keep sync1->sync2 a true two-stage pipeline.
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            if (changed) begin
                cnt_q <= '0;
            end else begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q >= CNT_LATCH) key_stable <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/move_position_encoder.sv
// Debounced 9-key to position 1..9 encoder with valid/ready hand-off to the turn FSM.
// Optional occupied-cell rejection is enabled by defining MOVE_OCC_CHECK_EN.
module move_position_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned N_CELLS         = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    move_position_encoder_if.master bus
);
    import move_position_encoder_pkg::*;

    logic [N_CELLS-1:0] key_stable;
    state_e             state_q;
    logic [POS_W-1:0]   pos_q;
    logic               valid_q;
    logic               err_multi_q;
    logic               err_occ_q;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (N_CELLS)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (bus.key_in),
        .key_stable(key_stable)
    );

`ifdef MOVE_OCC_CHECK_EN
    logic occ_hit;
    assign occ_hit = |(key_stable & bus.board_occ);
`else
    logic unused_board_occ;
    assign unused_board_occ = ^bus.board_occ;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_q       <= POS_NONE;
            valid_q     <= 1'b0;
            err_multi_q <= 1'b0;
            err_occ_q   <= 1'b0;
        end else begin
            err_multi_q <= 1'b0;
            err_occ_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_stable != '0) state_q <= CHECK;
                end
                CHECK: begin
                    if (popcount(key_stable) > 4'd1) begin
                        err_multi_q <= 1'b1;
                        state_q     <= RELEASE;
                    end
`ifdef MOVE_OCC_CHECK_EN
                    else if (occ_hit) begin
                        err_occ_q <= 1'b1;
                        state_q   <= RELEASE;
                    end
`endif
                    else if (key_stable != '0) begin
                        pos_q   <= encode_onehot(key_stable);
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.pos_ready) begin
                        pos_q   <= POS_NONE;
                        valid_q <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    // The key must be seen released before another press is accepted.
                    if (key_stable == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pos_out   = pos_q;
    assign bus.pos_valid = valid_q;
    assign bus.err_multi = err_multi_q;
    assign bus.err_occ   = err_occ_q;

endmodule
